// File: rtl/shared_mult_arbiter.sv
// Round-robin arbiter in front of one fully pipelined signed multiplier.
// Every enabled cycle, one requester is granted and its operand pair enters the pipeline.
// The result comes out LATENCY enabled cycles later, tagged with the requester index.
module shared_mult_arbiter #(
  parameter int IN_WIDTH  = 10,
  parameter int NUM_REQ   = 4,
  parameter int TAG_WIDTH = 2,
  parameter int LATENCY   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*IN_WIDTH-1:0]   A,
  input  logic [NUM_REQ*IN_WIDTH-1:0]   B,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          outReady,
  output logic [TAG_WIDTH-1:0]          outTag,
  output logic [2*IN_WIDTH-1:0]         DP,
  output logic [3:0]                    inFlight
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_check
    $error("shared_mult_arbiter: NUM_REQ must be in 2..8");
  end
  if ((1 << TAG_WIDTH) < NUM_REQ) begin : g_tag_width_check
    $error("shared_mult_arbiter: TAG_WIDTH too small for NUM_REQ");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_latency_check
    $error("shared_mult_arbiter: LATENCY must be in 1..8");
  end

  logic [TAG_WIDTH-1:0]          ptr;
  logic [TAG_WIDTH-1:0]          ptr_next;
  logic [TAG_WIDTH-1:0]          sel;
  logic [NUM_REQ-1:0]            masked;
  logic [NUM_REQ-1:0]            pick;
  logic                          issue;
  logic signed [IN_WIDTH-1:0]    op_a;
  logic signed [IN_WIDTH-1:0]    op_b;
  logic signed [2*IN_WIDTH-1:0]  prod;

  logic                          valid_pipe [LATENCY];
  logic [TAG_WIDTH-1:0]          tag_pipe   [LATENCY];
  logic signed [2*IN_WIDTH-1:0]  data_pipe  [LATENCY];
  logic [3:0]                    in_flight;

  // Round-robin select: the lowest requester at or above ptr wins.
  // If none is found there, the search wraps to the lowest requester overall.
  always_comb begin
    masked = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      masked[i] = req[i] && (i >= 32'(ptr));
    end
    pick = (masked != '0) ? masked : req;
    sel  = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (pick[i-1]) sel = TAG_WIDTH'(i - 1);
    end
    issue = !reset && enable && (req != '0);
    grant = '0;
    if (issue) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        grant[i] = (sel == TAG_WIDTH'(i));
      end
    end
    ptr_next = (sel == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : sel + TAG_WIDTH'(1);
  end

  // Operand mux for the selected requester and the full-precision signed product
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel == TAG_WIDTH'(i)) begin
        op_a = A[i*IN_WIDTH +: IN_WIDTH];
        op_b = B[i*IN_WIDTH +: IN_WIDTH];
      end
    end
    prod = op_a * op_b;
  end

  // Pointer, valid/tag/data shift pipeline and in-flight counter.
  // A stage loads new data only when the stage feeding it holds a valid entry.
  // Otherwise the stage keeps its old data, so the last stage holds the last delivered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      in_flight <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        valid_pipe[i] <= 1'b0;
        tag_pipe[i]   <= '0;
        data_pipe[i]  <= '0;
      end
    end else if (enable) begin
      if (issue) ptr <= ptr_next;
      valid_pipe[0] <= issue;
      if (issue) begin
        tag_pipe[0]  <= sel;
        data_pipe[0] <= prod;
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        if (valid_pipe[i-1]) begin
          tag_pipe[i]  <= tag_pipe[i-1];
          data_pipe[i] <= data_pipe[i-1];
        end
      end
      case ({issue, valid_pipe[LATENCY-1]})
        2'b10:   in_flight <= in_flight + 4'd1;
        2'b01:   in_flight <= in_flight - 4'd1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  assign outReady = valid_pipe[LATENCY-1];
  assign outTag   = tag_pipe[LATENCY-1];
  assign DP       = data_pipe[LATENCY-1];
  assign inFlight = in_flight;

endmodule

// File: tb/tb_shared_mult_arbiter.sv
// Directed bench for shared_mult_arbiter: round-robin order, latency, stall and reset behaviour.
module tb_shared_mult_arbiter;

  localparam int W  = 10;
  localparam int N  = 4;
  localparam int TW = 2;
  localparam int L  = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [N-1:0]    req;
  logic [N*W-1:0]  A;
  logic [N*W-1:0]  B;
  logic [N-1:0]    grant;
  logic            outReady;
  logic [TW-1:0]   outTag;
  logic [2*W-1:0]  DP;
  logic [3:0]      inFlight;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shared_mult_arbiter #(
    .IN_WIDTH (W),
    .NUM_REQ  (N),
    .TAG_WIDTH(TW),
    .LATENCY  (L)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .req     (req),
    .A       (A),
    .B       (B),
    .grant   (grant),
    .outReady(outReady),
    .outTag  (outTag),
    .DP      (DP),
    .inFlight(inFlight)
  );

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    A[i*W +: W] = a[W-1:0];
    B[i*W +: W] = b[W-1:0];
  endtask

  task automatic check_out(input string tag, input int rdy, input int t, input int d);
    check_eq({tag, "_rdy"}, 32'(outReady), rdy);
    check_eq({tag, "_tag"}, 32'(outTag), t);
    check_eq({tag, "_dp"}, $signed(DP), d);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    req    = '1;
    A      = '0;
    B      = '0;
    tick();
    tick();

    // During reset: no grant and all outputs cleared
    check_eq("rst_grant", 32'(grant), 0);
    check_out("rst", 0, 0, 0);
    check_eq("rst_inflight", 32'(inFlight), 0);

    // Round-robin over all four requesters with A_i=i+1 and B_i=3
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, i + 1, 3);
    for (int c = 0; c < 8; c++) begin
      #1;
      check_eq("rr_grant", 32'(grant), 1 << (c % 4));
      check_eq("rr_rdy", 32'(outReady), (c >= 2) ? 1 : 0);
      if (c >= 2) begin
        check_eq("rr_tag", 32'(outTag), (c - 2) % 4);
        check_eq("rr_dp", $signed(DP), 3 * ((c - 2) % 4 + 1));
      end
      check_eq("rr_inflight", 32'(inFlight), (c == 0) ? 0 : ((c == 1) ? 1 : 2));
      tick();
    end
    req = '0;
    #1;
    check_out("drain0", 1, 2, 9);
    check_eq("drain0_inflight", 32'(inFlight), 2);
    tick();
    #1;
    check_out("drain1", 1, 3, 12);
    check_eq("drain1_inflight", 32'(inFlight), 1);
    tick();
    #1;
    check_out("drain_hold", 0, 3, 12);
    check_eq("drain_inflight", 32'(inFlight), 0);

    // Most negative operand squared is exact: -512 * -512
    set_op(2, -512, -512);
    req = 4'b0100;
    #1;
    check_eq("neg_grant", 32'(grant), 4);
    tick();
    req = '0;
    #1;
    check_eq("neg_rdy_early", 32'(outReady), 0);
    check_eq("neg_inflight", 32'(inFlight), 1);
    tick();
    #1;
    check_out("neg", 1, 2, 262144);
    tick();
    #1;
    check_out("neg_hold", 0, 2, 262144);

    // ptr=3 now: req 1001 grants 3 first, then wraps to 0
    set_op(3, -7, 5);
    set_op(0, 100, -3);
    req = 4'b1001;
    #1;
    check_eq("wrap_grant3", 32'(grant), 8);
    tick();
    #1;
    check_eq("wrap_grant0", 32'(grant), 1);
    tick();
    req = '0;
    #1;
    check_out("wrap3", 1, 3, -35);
    tick();
    #1;
    check_out("wrap0", 1, 0, -300);
    tick();
    #1;
    check_eq("wrap_rdy_off", 32'(outReady), 0);
    check_eq("wrap_inflight", 32'(inFlight), 0);

    // Three back-to-back ops (ptr=1) with a five-cycle stall after the second grant
    set_op(1, 11, -13);
    set_op(2, -512, 511);
    set_op(3, 511, 511);
    req = 4'b1110;
    #1;
    check_eq("stall_g1", 32'(grant), 2);
    tick();
    #1;
    check_eq("stall_g2", 32'(grant), 4);
    tick();
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("stall_grant", 32'(grant), 0);
      check_out("stall", 1, 1, -143);
      check_eq("stall_inflight", 32'(inFlight), 2);
      tick();
    end
    enable = 1'b1;
    #1;
    check_eq("stall_g3", 32'(grant), 8);
    check_out("stall_r1", 1, 1, -143);
    check_eq("stall_r1_inflight", 32'(inFlight), 2);
    tick();
    req = '0;
    #1;
    check_out("stall_r2", 1, 2, -261632);
    check_eq("stall_r2_inflight", 32'(inFlight), 2);
    tick();
    #1;
    check_out("stall_r3", 1, 3, 261121);
    check_eq("stall_r3_inflight", 32'(inFlight), 1);
    tick();
    #1;
    check_eq("stall_done_rdy", 32'(outReady), 0);
    check_eq("stall_done_inflight", 32'(inFlight), 0);

    // Two ops, then reset: the operation still in the pipeline is discarded
    set_op(0, 9, 9);
    set_op(1, -4, 4);
    req = 4'b0001;
    #1;
    check_eq("rstfl_g0", 32'(grant), 1);
    tick();
    req = 4'b0010;
    #1;
    check_eq("rstfl_g1", 32'(grant), 2);
    tick();
    reset = 1'b1;
    req   = 4'b1111;
    #1;
    check_eq("rstfl_grant_in_reset", 32'(grant), 0);
    tick();
    reset = 1'b0;
    req   = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_out("rstfl_quiet", 0, 0, 0);
      check_eq("rstfl_inflight", 32'(inFlight), 0);
      tick();
    end

    // With all requesting, the first grant after reset goes to requester 0
    req = 4'b1111;
    #1;
    check_eq("post_rst_grant", 32'(grant), 1);
    tick();
    req = '0;
    #1;
    check_eq("post_rst_inflight", 32'(inFlight), 1);
    tick();
    #1;
    check_out("post_rst", 1, 0, 81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
